// File: rtl/decodificador_pwm_servo.sv
// Servo PWM receiver: measures each high pulse in clock cycles, decodes it to a
// 3-bit position, and flags malformed pulses and loss of signal.
module decodificador_pwm_servo #(
  parameter int N           = 21,
  parameter int LARGURA_MIN = 50_000,
  parameter int PASSO       = 7_143,
  parameter int TIMEOUT     = 2_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pwm,
  output logic [2:0]   posicao,
  output logic [N-1:0] largura,
  output logic         valido,
  output logic         erro,
  output logic         sem_sinal,
  output logic [3:0]   db_estado
);

  localparam int LIMITE = LARGURA_MIN + 8 * PASSO;
  localparam logic [N-1:0] LIMITE_N    = N'(LIMITE);
  localparam logic [N-1:0] MINIMO_N    = N'(LARGURA_MIN / 2);
  localparam logic [N-1:0] TIMEOUT_N   = N'(TIMEOUT);

  typedef enum logic [1:0] {
    ESPERA_BAIXO  = 2'd0,
    ESPERA_SUBIDA = 2'd1,
    MEDE_ALTO     = 2'd2,
    REGISTRA      = 2'd3
  } estado_t;

  estado_t estado, prox_estado;

  logic         sync_a, sync_b, prev;
  logic         subida, descida;
  logic [N-1:0] cnt_largura;
  logic [N-1:0] cnt_timeout;
  logic         aceito;
  logic         aceita;
  logic [2:0]   pos_calc;

  // Synchronizer and history reset high so that a pulse already in progress
  // at reset release can never look like a fresh rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      prev   <= 1'b1;
    end else begin
      sync_a <= pwm;
      sync_b <= sync_a;
      prev   <= sync_b;
    end
  end

  assign subida  = sync_b & ~prev;
  assign descida = ~sync_b & prev;

  always_comb begin
    pos_calc = 3'd0;
    for (int j = 1; j <= 7; j++) begin
      if (cnt_largura >= N'(LARGURA_MIN + j * PASSO - PASSO / 2))
        pos_calc = pos_calc + 3'd1;
    end
  end

  assign aceita = (cnt_largura >= MINIMO_N) && (cnt_largura <= LIMITE_N);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= ESPERA_BAIXO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    valido      = 1'b0;
    erro        = 1'b0;
    case (estado)
      ESPERA_BAIXO:  if (!sync_b) prox_estado = ESPERA_SUBIDA;
      ESPERA_SUBIDA: if (subida) prox_estado = MEDE_ALTO;
      MEDE_ALTO: begin
        if (descida) begin
          prox_estado = REGISTRA;
        end else if (sync_b && (cnt_largura > LIMITE_N)) begin
          erro        = 1'b1;
          prox_estado = ESPERA_BAIXO;
        end
      end
      REGISTRA: begin
        valido      = aceito;
        erro        = ~aceito;
        prox_estado = ESPERA_SUBIDA;
      end
      default: prox_estado = ESPERA_BAIXO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_largura <= '0;
      aceito      <= 1'b0;
      largura     <= '0;
      posicao     <= 3'd0;
    end else begin
      case (estado)
        ESPERA_SUBIDA: if (subida) cnt_largura <= N'(1);
        MEDE_ALTO: begin
          if (descida) begin
            aceito <= aceita;
            if (aceita) begin
              largura <= cnt_largura;
              posicao <= pos_calc;
            end
          end else if (sync_b) begin
            cnt_largura <= cnt_largura + N'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating loss-of-signal counter, independent of the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_timeout <= '0;
    end else if (subida) begin
      cnt_timeout <= '0;
    end else if (cnt_timeout != TIMEOUT_N) begin
      cnt_timeout <= cnt_timeout + N'(1);
    end
  end

  assign sem_sinal = (cnt_timeout == TIMEOUT_N) && !subida;
  assign db_estado = {2'b00, estado};

endmodule
